// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the register hazard scoreboard: address/latency
// defaults, the per-source operand select encoding and latency normalisation.
package hazard_scoreboard_pkg;

  localparam int unsigned RegAddrWidthDef = 5;
  localparam int unsigned NumSrcDef       = 2;
  localparam int unsigned MaxLatDef       = 4;
  localparam int unsigned FlushWindowDef  = 2;

  typedef logic [RegAddrWidthDef-1:0]       reg_addr_t;
  typedef logic [$clog2(MaxLatDef+1)-1:0]   lat_t;

  // Where a source operand comes from this cycle.
  typedef enum logic [1:0] {
    FwdSelRf     = 2'd0,
    FwdSelBypass = 2'd1,
    FwdSelStall  = 2'd2
  } fwd_sel_e;

  // Zero or out-of-range latencies are treated as the slowest producer.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    return ((lat == 0) || (lat > max_lat)) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One tracked architectural register: cycles-until-bypass counter plus an age
// used to decide whether a branch flush squashes the pending write.
module hazard_scoreboard_entry #(
  parameter int unsigned MaxLat      = 4,
  parameter int unsigned FlushWindow = 2,
  localparam int unsigned CntW       = $clog2(MaxLat + 1),
  localparam int unsigned AgeW       = $clog2(FlushWindow + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_lat_i,
  input  logic            flush_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic [AgeW-1:0] age_d, age_q;

  always_comb begin
    cnt_d = cnt_q;
    age_d = age_q;
    if (age_q != AgeW'(FlushWindow)) begin
      age_d = age_q + AgeW'(1);
    end
    if (flush_i && (age_q < AgeW'(FlushWindow))) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
    // A new producer overrides whatever the retiring one was doing.
    if (load_i) begin
      cnt_d = load_lat_i;
      age_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      age_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      age_q <= age_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: tracks in-flight register writes, raises RAW/WAW stalls,
// selects bypass for operands whose producer completes this cycle.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDef,
  parameter int unsigned NUM_SRC        = NumSrcDef,
  parameter int unsigned MAX_LAT        = MaxLatDef,
  parameter int unsigned FWD_EN         = 1,
  parameter int unsigned FLUSH_WINDOW   = FlushWindowDef
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issueValid,
  input  logic                              issueWEnable,
  input  logic [REG_ADDR_WIDTH-1:0]         issueRdAddr,
  input  logic [$clog2(MAX_LAT+1)-1:0]      issueLatency,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] srcAddr,
  input  logic [NUM_SRC-1:0]                srcUsed,
  input  logic                              flush,
  output logic                              stall,
  output logic [NUM_SRC-1:0]                srcFwd,
  output logic [REG_ADDR_WIDTH:0]           pendingCount
);

  localparam int unsigned NumRegs   = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned LatW      = $clog2(MAX_LAT + 1);
  // With a bypass, a producer one cycle from completion can feed the consumer directly.
  localparam int unsigned RawThresh = (FWD_EN != 0) ? 1 : 0;

  logic [LatW-1:0]           cnt [NumRegs];
  logic [LatW-1:0]           lat_eff;
  logic                      raw_hazard;
  logic                      waw_hazard;
  logic                      issue_accept;
  logic                      flush_eff;
  logic [REG_ADDR_WIDTH-1:0] src_addr [NUM_SRC];
  fwd_sel_e                  src_sel  [NUM_SRC];
  logic [REG_ADDR_WIDTH:0]   pend_d, pend_q;

  assign lat_eff = LatW'(clamp_lat(32'(issueLatency), MAX_LAT));

  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_addr[i] = srcAddr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      src_sel[i]  = FwdSelRf;
      if (srcUsed[i] && (src_addr[i] != '0)) begin
        if (cnt[src_addr[i]] > LatW'(RawThresh)) begin
          src_sel[i] = FwdSelStall;
        end else if ((FWD_EN != 0) && (cnt[src_addr[i]] == LatW'(1))) begin
          src_sel[i] = FwdSelBypass;
        end
      end
      raw_hazard = raw_hazard | (src_sel[i] == FwdSelStall);
    end
  end

  // A younger write must not complete before an older one to the same register.
  assign waw_hazard = issueValid & issueWEnable & (issueRdAddr != '0) &
                      (cnt[issueRdAddr] > lat_eff);

  assign stall = ~rst & issueValid & ~flush & (raw_hazard | waw_hazard);

  always_comb begin
    srcFwd = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      srcFwd[i] = ~stall & (src_sel[i] == FwdSelBypass);
    end
  end

  assign issue_accept = ~rst & issueValid & issueWEnable & (issueRdAddr != '0) &
                        ~stall & ~flush;
  assign flush_eff    = flush & ~rst;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NumRegs; r++) begin : g_entry
    hazard_scoreboard_entry #(
      .MaxLat      (MAX_LAT),
      .FlushWindow (FLUSH_WINDOW)
    ) u_entry (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (issue_accept && (issueRdAddr == REG_ADDR_WIDTH'(r))),
      .load_lat_i (lat_eff),
      .flush_i    (flush_eff),
      .cnt_o      (cnt[r])
    );
  end

  always_comb begin
    pend_d = '0;
    for (int r = 1; r < int'(NumRegs); r++) begin
      if (cnt[r] != '0) begin
        pend_d = pend_d + (REG_ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pendingCount = pend_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (bypass present / absent) share stimulus
// and are compared every cycle against a per-register countdown model.
module tb_hazard_scoreboard;

  localparam int W  = 5;
  localparam int ML = 4;
  localparam int FW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       issueValid, issueWEnable, flush;
  logic [4:0] issueRdAddr;
  logic [2:0] issueLatency;
  logic [9:0] srcAddr;
  logic [1:0] srcUsed;

  logic       stall_f, stall_n;
  logic [1:0] fwd_f, fwd_n;
  logic [5:0] pend_f, pend_n;

  int checks = 0;
  int errors = 0;

  // Model state: [0] = bypass instance, [1] = no-bypass instance.
  int m_cnt  [2][32];
  int m_age  [2][32];
  int m_pend [2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_WIDTH(W), .NUM_SRC(2), .MAX_LAT(ML), .FWD_EN(1),
                      .FLUSH_WINDOW(FW)) u_dut_fwd (
    .clk(clk), .rst(rst), .issueValid(issueValid), .issueWEnable(issueWEnable),
    .issueRdAddr(issueRdAddr), .issueLatency(issueLatency), .srcAddr(srcAddr),
    .srcUsed(srcUsed), .flush(flush), .stall(stall_f), .srcFwd(fwd_f), .pendingCount(pend_f)
  );

  hazard_scoreboard #(.REG_ADDR_WIDTH(W), .NUM_SRC(2), .MAX_LAT(ML), .FWD_EN(0),
                      .FLUSH_WINDOW(FW)) u_dut_nofwd (
    .clk(clk), .rst(rst), .issueValid(issueValid), .issueWEnable(issueWEnable),
    .issueRdAddr(issueRdAddr), .issueLatency(issueLatency), .srcAddr(srcAddr),
    .srcUsed(srcUsed), .flush(flush), .stall(stall_n), .srcFwd(fwd_n), .pendingCount(pend_n)
  );

  function automatic int eff_lat(input int l);
    return ((l == 0) || (l > ML)) ? ML : l;
  endfunction

  function automatic bit exp_stall(input int k);
    bit haz;
    int a;
    haz = 1'b0;
    if (rst || !issueValid || flush) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = int'(srcAddr[i*W +: W]);
      if (srcUsed[i] && (a != 0) && (m_cnt[k][a] > ((k == 0) ? 1 : 0))) haz = 1'b1;
    end
    if (issueWEnable && (issueRdAddr != 0) &&
        (m_cnt[k][issueRdAddr] > eff_lat(int'(issueLatency)))) haz = 1'b1;
    return haz;
  endfunction

  function automatic int exp_fwd(input int k);
    int f;
    int a;
    f = 0;
    if ((k == 0) && !rst && !exp_stall(k)) begin
      for (int i = 0; i < 2; i++) begin
        a = int'(srcAddr[i*W +: W]);
        if (srcUsed[i] && (a != 0) && (m_cnt[k][a] == 1)) f = f | (1 << i);
      end
    end
    return f;
  endfunction

  function automatic int busy_regs(input int k);
    int n;
    n = 0;
    for (int r = 1; r < 32; r++) if (m_cnt[k][r] != 0) n++;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] <= 0;
        for (int r = 0; r < 32; r++) begin
          m_cnt[k][r] <= 0;
          m_age[k][r] <= 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] <= busy_regs(k);
        for (int r = 1; r < 32; r++) begin
          if (flush && (m_age[k][r] < FW)) m_cnt[k][r] <= 0;
          else if (m_cnt[k][r] > 0) m_cnt[k][r] <= m_cnt[k][r] - 1;
          if (m_age[k][r] < FW) m_age[k][r] <= m_age[k][r] + 1;
        end
        if (issueValid && issueWEnable && (issueRdAddr != 0) && !flush && !exp_stall(k)) begin
          m_cnt[k][issueRdAddr] <= eff_lat(int'(issueLatency));
          m_age[k][issueRdAddr] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_stall_fwd",   int'(stall_f), int'(exp_stall(0)));
    chk("model_stall_nofwd", int'(stall_n), int'(exp_stall(1)));
    chk("model_srcfwd_fwd",   int'(fwd_f), exp_fwd(0));
    chk("model_srcfwd_nofwd", int'(fwd_n), exp_fwd(1));
    chk("model_pend_fwd",   int'(pend_f), m_pend[0]);
    chk("model_pend_nofwd", int'(pend_n), m_pend[1]);
  end

  task automatic drive(input bit v, input bit we, input int rd, input int lat, input int s0,
                       input int s1, input logic [1:0] used, input bit fl);
    issueValid   = v;
    issueWEnable = we;
    issueRdAddr  = 5'(rd);
    issueLatency = 3'(lat);
    srcAddr      = {5'(s1), 5'(s0)};
    srcUsed      = used;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    step();
    // Issue and flush presented while in reset must be ignored.
    drive(1, 1, 5, 3, 0, 0, 2'b00, 1);
    #1 chk("rst_stall", int'(stall_f), 0);
    step();
    chk("rst_pend", int'(pend_f), 0);
    rst = 1'b0;
    drive(1, 0, 0, 0, 5, 0, 2'b01, 0);
    #1 chk("rst_ignored_issue", int'(stall_f), 0);
    step();

    // RAW on r5 (latency 3): consumer sees cnt 3,2,1.
    drive(1, 1, 5, 3, 0, 0, 2'b00, 0);
    #1 chk("raw_issue_stall", int'(stall_f), 0);
    step();
    drive(1, 0, 0, 0, 5, 0, 2'b01, 0);
    #1 chk("raw_c1_stall_fwd", int'(stall_f), 1);
    chk("raw_c1_stall_nofwd", int'(stall_n), 1);
    step();
    #1 chk("raw_c2_stall_fwd", int'(stall_f), 1);
    chk("raw_c2_pend", int'(pend_f), 1);
    step();
    #1 chk("raw_c3_stall_fwd", int'(stall_f), 0);
    chk("raw_c3_srcfwd", int'(fwd_f), 1);
    chk("raw_c3_stall_nofwd", int'(stall_n), 1);
    chk("raw_c3_srcfwd_nofwd", int'(fwd_n), 0);
    step();
    #1 chk("raw_c4_stall_nofwd", int'(stall_n), 0);
    chk("raw_c4_srcfwd", int'(fwd_f), 0);
    step();
    idle(2);

    // WAW on r7: lat 4 then lat 1 waits until cnt[7] <= 1.
    drive(1, 1, 7, 4, 0, 0, 2'b00, 0);
    step();
    drive(1, 1, 7, 1, 0, 0, 2'b00, 0);
    #1 chk("waw_c1_stall", int'(stall_f), 1);
    step();
    step();
    step();
    #1 chk("waw_c4_release", int'(stall_f), 0);
    step();
    drive(1, 1, 0, 4, 0, 0, 2'b11, 0);
    #1 chk("r0_never_stall_fwd", int'(stall_f), 0);
    chk("r0_never_stall_nofwd", int'(stall_n), 0);
    step();
    idle(2);

    // Latency 0 and 7 both saturate to 4.
    drive(1, 1, 10, 0, 0, 0, 2'b00, 0);
    step();
    drive(1, 1, 10, 7, 0, 0, 2'b00, 0);
    #1 chk("sat_c1_stall", int'(stall_f), 0);
    step();
    drive(1, 1, 10, 3, 0, 0, 2'b00, 0);
    #1 chk("sat_c2_waw", int'(stall_f), 1);
    step();
    idle(5);

    // Flush: r9 is old enough to survive, r3 is squashed.
    drive(1, 1, 9, 4, 0, 0, 2'b00, 0);
    step();
    idle(1);
    drive(1, 1, 3, 4, 0, 0, 2'b00, 0);
    step();
    drive(1, 1, 11, 2, 9, 0, 2'b01, 1);
    #1 chk("flush_stall", int'(stall_f), 0);
    step();
    drive(1, 0, 0, 0, 3, 9, 2'b11, 0);
    #1 chk("flush_r3_clear", int'(stall_f), 0);
    chk("flush_r9_fwd", int'(fwd_f), 2);
    chk("flush_pend_before", int'(pend_f), 2);
    chk("flush_r9_nofwd", int'(stall_n), 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    #1 chk("flush_pend_after", int'(pend_f), 1);
    step();
    idle(2);

    // Asynchronous reset with writes in flight.
    drive(1, 1, 8, 4, 0, 0, 2'b00, 0);
    step();
    drive(1, 1, 4, 2, 0, 0, 2'b00, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
    #1 chk("prerst_pend", int'(pend_f), 1);
    rst = 1'b1;
    #1 chk("midrst_pend_fwd", int'(pend_f), 0);
    chk("midrst_pend_nofwd", int'(pend_n), 0);
    step();
    rst = 1'b0;
    drive(1, 0, 0, 0, 4, 0, 2'b01, 0);
    #1 chk("postrst_stall_fwd", int'(stall_f), 0);
    chk("postrst_stall_nofwd", int'(stall_n), 0);
    chk("postrst_pend", int'(pend_f), 0);
    step();

    // srcUsed gating on source 1.
    drive(1, 1, 6, 3, 0, 0, 2'b00, 0);
    step();
    drive(1, 0, 0, 0, 0, 6, 2'b00, 0);
    #1 chk("unused_src_stall", int'(stall_f), 0);
    step();
    idle(3);
    drive(1, 1, 6, 3, 0, 0, 2'b00, 0);
    step();
    drive(1, 0, 0, 0, 0, 6, 2'b10, 0);
    #1 chk("used_src_stall_fwd", int'(stall_f), 1);
    chk("used_src_stall_nofwd", int'(stall_n), 1);
    step();

    // Deterministic mixed traffic, checked by the per-cycle model only.
    for (int i = 0; i < 80; i++) begin
      drive((i % 5) != 4, (i % 3) != 2, (i * 7) % 32, i % 6, (i * 3) % 32, (i * 5) % 32,
            2'(i % 4), (i % 11) == 10);
      step();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
